// File: rtl/pe_rx_buffer_pkg.sv
// Shared types and constants for the per-PE receive buffer.
package pe_rx_buffer_pkg;

  localparam int WORD_SIZE_DEF = 256;
  localparam int NOF_PES_DEF   = 16;
  localparam int DEPTH_DEF     = 4;

  // Widths derived from the default system configuration.
  localparam int NOF_LEVELS = $clog2(NOF_PES_DEF);
  localparam int PTR_W      = $clog2(DEPTH_DEF);
  localparam int RX_COUNT_W = 16;

  // One queued entry: routed word plus the PE it came from.
  typedef struct packed {
    logic [WORD_SIZE_DEF-1:0] data;
    logic [NOF_LEVELS-1:0]    src;
  } rx_entry_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [RX_COUNT_W-1:0] sat_inc(input logic [RX_COUNT_W-1:0] v);
    if (v == {RX_COUNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + RX_COUNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/pe_rx_fifo_mem.sv
// Register-array storage for the receive FIFO: one write port, one
// asynchronous read port. Contents are intentionally not reset.
module pe_rx_fifo_mem
  import pe_rx_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WORD_SIZE_DEF + NOF_LEVELS,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Store the incoming entry at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/pe_rx_buffer.sv
// Per-PE receive buffer: queues words routed to this PE, drops and flags
// words carrying another PE's destination, and hands them out via valid/ready.
module pe_rx_buffer
  import pe_rx_buffer_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int NOF_PES   = NOF_PES_DEF,
  parameter int PE_INDEX  = 0,
  parameter int DEPTH     = DEPTH_DEF,
  localparam int LVL_W    = $clog2(NOF_PES),
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WORD_SIZE-1:0]  in_data,
  input  logic [LVL_W-1:0]      in_src_index,
  input  logic [LVL_W-1:0]      in_dest_index,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WORD_SIZE-1:0]  out_data,
  output logic [LVL_W-1:0]      out_src_index,
  input  logic                  out_ready,
  output logic [AW:0]           level,
  output logic                  misroute_err,
  output logic [RX_COUNT_W-1:0] rx_count
);

  localparam int EW = WORD_SIZE + LVL_W;

  logic [AW:0]           wr_ptr_r;
  logic [AW:0]           rd_ptr_r;
  logic                  ready_en_r;
  logic                  misroute_err_r;
  logic [RX_COUNT_W-1:0] rx_count_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  dest_ok_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  misroute_s;
  logic [EW-1:0]         rd_entry_s;

  // Wrap-bit pointer compare: same slot with differing MSB means full.
  assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign dest_ok_s  = (in_dest_index == LVL_W'(PE_INDEX));

  // ready_en_r keeps in_ready low until the first edge after reset release.
  assign in_ready   = ready_en_r & ~full_s;
  assign out_valid  = ~empty_s;
  assign push_s     = in_valid & in_ready & dest_ok_s;
  assign misroute_s = in_valid & in_ready & ~dest_ok_s;
  assign pop_s      = out_valid & out_ready;

  assign level      = wr_ptr_r - rd_ptr_r;
  assign misroute_err = misroute_err_r;
  assign rx_count   = rx_count_r;

  pe_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata ({in_data, in_src_index}),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (rd_entry_s)
  );

  // Head entry is masked to zero while empty so stale storage never shows.
  always_comb begin
    if (empty_s) begin
      {out_data, out_src_index} = '0;
    end else begin
      {out_data, out_src_index} = rd_entry_s;
    end
  end

  // Pointer, status flag and accepted-word counter updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      ready_en_r     <= 1'b0;
      misroute_err_r <= 1'b0;
      rx_count_r     <= '0;
    end else begin
      ready_en_r <= 1'b1;
      if (push_s) begin
        wr_ptr_r   <= wr_ptr_r + (AW+1)'(1);
        rx_count_r <= sat_inc(rx_count_r);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
      if (misroute_s) begin
        misroute_err_r <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pe_rx_buffer.md
Name: pe_rx_buffer

Overview:
- Per-PE receive buffer between the xconnect output lanes and a PE's input port; one instance per PE.
- Captures the routed data word together with its source PE index, and queues up to DEPTH words.
- Presents the queued words to the PE with a valid/ready handshake.
- Checks that each word's destination index matches this PE and flags misrouted words.

Parameters:
- WORD_SIZE, 256, data word width in bits.
- NOF_PES, 16, number of PEs in the system; power of 2, at least 2.
- PE_INDEX, 0, index of the PE that owns this instance; range 0..NOF_PES-1.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- Derived: NOF_LEVELS = clog2(NOF_PES); PTR_W = clog2(DEPTH).

Ports:
- clk  in  1  single clock; all state is on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion is synchronous to clk.
- in_valid  in  1  the xconnect lane holds a word.
- in_data  in  WORD_SIZE  word from the xconnect lane.
- in_src_index  in  NOF_LEVELS  source PE index of the word.
- in_dest_index  in  NOF_LEVELS  destination PE index of the word.
- in_ready  out  1  the buffer can accept a word.
- out_valid  out  1  the head entry is valid.
- out_data  out  WORD_SIZE  head word.
- out_src_index  out  NOF_LEVELS  source PE index of the head word.
- out_ready  in  1  the PE consumes the head word.
- level  out  PTR_W+1  current occupancy, 0..DEPTH.
- misroute_err  out  1  sticky flag: a word arrived with the wrong destination.
- rx_count  out  16  saturating count of accepted words.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers cleared; level=0; out_valid=0; misroute_err=0; rx_count=0.
  - in_ready=0 while rst=0, then 1 from the first clock after deassertion.
  - out_data and out_src_index read 0 after reset; FIFO storage contents are not reset.
  - Reset during any activity discards all queued words immediately.
- Pointers: wr_ptr and rd_ptr are PTR_W+1 bits, with a wrap bit.
  - full when the pointers differ only in the MSB; empty when the pointers are equal.
  - level = wr_ptr - rd_ptr, computed modulo 2^(PTR_W+1).
- Input handshake:
  - in_ready = !full (registered-state based; no combinational path from out_ready).
  - A push requires in_valid & in_ready & (in_dest_index == PE_INDEX).
  - A push writes {in_data, in_src_index} at wr_ptr[PTR_W-1:0] and increments wr_ptr, wrapping naturally.
- Misroute:
  - Condition: in_valid & in_ready & (in_dest_index != PE_INDEX).
  - The word is dropped, misroute_err is set to 1 on the next edge and holds until reset, and rx_count is unchanged.
- Output handshake:
  - out_valid = !empty.
  - out_data and out_src_index show the entry at rd_ptr.
  - A pop requires out_valid & out_ready and increments rd_ptr.
- Latency: a word pushed at edge N is visible on out_valid/out_data after edge N. There is no same-cycle bypass when empty.
- Simultaneous push and pop:
  - When not full: both occur and level is unchanged.
  - When full: in_ready=0, so only the pop occurs. The push is accepted on the following cycle.
- out_ready while empty: ignored; no pointer change.
- rx_count: increments on each push and saturates at 16'hFFFF.
- Data on out_* is held stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package holds:
  - the clog2-derived widths NOF_LEVELS and PTR_W;
  - the entry record {data[WORD_SIZE], src[NOF_LEVELS]} typedef;
  - the RX_COUNT_W=16 constant.
- One natural sub-module, pe_rx_fifo_mem: a DEPTH x (WORD_SIZE+NOF_LEVELS) register array with a write port and an asynchronous read port.
- Pointer, flag and counter logic stays in pe_rx_buffer.

Test Plan:
- Reset then idle (PE_INDEX=3): after rst release, in_ready=1, out_valid=0, level=0, misroute_err=0, rx_count=0.
- Single word (in_data=256'hA5, src=5, dest=3, out_ready=0): one cycle later out_valid=1, out_data=256'hA5, out_src_index=5, level=1, rx_count=1.
- Fill to full with DEPTH=4, out_ready=0, words 1..4 and a 5th held with in_valid=1:
  - level=4, in_ready=0, and the 5th word is not accepted.
  - Raising out_ready for one cycle pops word 1; the 5th is accepted on the next cycle, and order 2,3,4,5 is preserved.
- Streaming with in_valid=1 and out_ready=1 for 20 cycles: level stays at 1, every word emerges in order one cycle after push, and rx_count=20.
- Misroute (dest=7 with PE_INDEX=3): the word is dropped, level is unchanged, misroute_err=1 and stays 1 through subsequent good traffic until rst=0.
- Reset mid-operation: with level=3, assert rst=0 asynchronously mid-cycle. Immediately out_valid=0, level=0, in_ready=0; after release, the buffer is empty and the next word pushes normally.
